// File: rtl/bram_buf_pkg.sv
// Shared types and helpers for the BRAM store-then-forward reorder buffer.
package bram_buf_pkg;

   typedef enum logic {
      RECV  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   localparam int SWAP_MAX_W = 1024;
   localparam int SWAP_IDX_W = $clog2(SWAP_MAX_W);

   // Reverses word order in the low data_w bits; callers zero-extend in and truncate out.
   function automatic logic [SWAP_MAX_W-1:0] word_swap(input logic [SWAP_MAX_W-1:0] data,
                                                       input int data_w,
                                                       input int word_w);
      logic [SWAP_MAX_W-1:0] res;
      logic [SWAP_IDX_W-1:0] dst;
      logic [SWAP_IDX_W-1:0] src;
      int                    nw;
      res = '0;
      nw  = data_w / word_w;
      for (int b = 0; b < SWAP_MAX_W; b++) begin
         dst = SWAP_IDX_W'(b);
         src = SWAP_IDX_W'((nw - 1 - b / word_w) * word_w + b % word_w);
         if (b < data_w)
            res[dst] = data[src];
      end
      return res;
   endfunction

endpackage

// File: rtl/bram_sdp_1clk.sv
// Simple dual-port single-clock RAM: one write port, one registered read port with enable.
module bram_sdp_1clk #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_W     = 14
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  r_en_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we_i)
         mem_q[waddr_i] <= wdata_i;
      if (r_en_i)
         rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/bram_reorder_buffer.sv
// Store-then-forward frame buffer: fills BRAM with one frame, then streams it out
// in forward or reverse beat order with optional word reversal inside each beat.
module bram_reorder_buffer
   import bram_buf_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int WORD_WIDTH = 32,
   parameter int DEPTH      = 16384,
   parameter int ADDR_W     = $clog2(DEPTH),
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [19:0]           num_data,
   input  logic                  rev_order,
   input  logic                  swap_words,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  cfg_err
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_e                state_q;
   logic [CNT_W-1:0]      wr_cnt_q, rd_idx_q, out_idx_q, len_q;
   logic                  rev_q, swap_q, started_q, rdy_en_q;
   logic                  busy_q, frame_done_q, cfg_err_q;
   logic                  inflight_q;
   logic [DATA_WIDTH-1:0] fifo_q [0:1];
   logic                  fifo_wp_q, fifo_rp_q;
   logic [1:0]            fifo_cnt_q;

   logic [CNT_W-1:0]      len_in, len_cur;
   logic [ADDR_W-1:0]     rd_addr;
   logic [2:0]            occ;
   logic                  in_acc, last_in, pop, last_out, rd_en, push;
   logic [DATA_WIDTH-1:0] ram_dout, head, head_sw;

   assign len_in   = (num_data > 20'(DEPTH)) ? CNT_W'(DEPTH) : num_data[CNT_W-1:0];
   assign len_cur  = started_q ? len_q : len_in;

   // rdy_en_q keeps in_ready low until the first edge after reset release.
   assign in_ready = rdy_en_q && (state_q == RECV) && (started_q || (num_data != '0));
   assign in_acc   = in_valid && in_ready;
   assign last_in  = in_acc && (wr_cnt_q == len_cur - ONE);

   assign out_valid = (fifo_cnt_q != 2'd0);
   assign pop       = out_valid && out_ready;
   assign push      = inflight_q;
   assign last_out  = pop && (out_idx_q == len_q - ONE);

   // A same-cycle pop frees a slot before the issued read lands, sustaining 1 beat/cycle.
   assign occ     = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
   assign rd_en   = (state_q == DRAIN) && (rd_idx_q < len_q) && (occ < 3'd2);
   assign rd_addr = rev_q ? ADDR_W'(len_q - ONE - rd_idx_q) : ADDR_W'(rd_idx_q);

   assign head     = fifo_q[fifo_rp_q];
   assign head_sw  = DATA_WIDTH'(word_swap(SWAP_MAX_W'(head), DATA_WIDTH, WORD_WIDTH));
   assign out_data = out_valid ? (swap_q ? head_sw : head) : '0;

   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign cfg_err    = cfg_err_q;

   bram_sdp_1clk #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_W    (ADDR_W)
   ) u_ram (
      .clk    (clk),
      .we_i   (in_acc),
      .waddr_i(ADDR_W'(wr_cnt_q)),
      .wdata_i(in_data),
      .r_en_i (rd_en),
      .raddr_i(rd_addr),
      .rdata_o(ram_dout)
   );

   always_ff @(posedge clk) begin
      if (push)
         fifo_q[fifo_wp_q] <= ram_dout;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RECV;
         wr_cnt_q     <= '0;
         rd_idx_q     <= '0;
         out_idx_q    <= '0;
         len_q        <= '0;
         rev_q        <= 1'b0;
         swap_q       <= 1'b0;
         started_q    <= 1'b0;
         rdy_en_q     <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
         inflight_q   <= 1'b0;
         fifo_wp_q    <= 1'b0;
         fifo_rp_q    <= 1'b0;
         fifo_cnt_q   <= 2'd0;
      end else begin
         rdy_en_q     <= 1'b1;
         frame_done_q <= 1'b0;
         inflight_q   <= rd_en;
         fifo_cnt_q   <= fifo_cnt_q + 2'(push) - 2'(pop);
         if (push)
            fifo_wp_q <= ~fifo_wp_q;
         if (pop)
            fifo_rp_q <= ~fifo_rp_q;
         if (rd_en)
            rd_idx_q <= rd_idx_q + ONE;
         if (pop)
            out_idx_q <= out_idx_q + ONE;

         case (state_q)
            RECV: begin
               if (!started_q && (num_data == '0))
                  cfg_err_q <= 1'b1;
               if (in_acc) begin
                  wr_cnt_q <= wr_cnt_q + ONE;
                  busy_q   <= 1'b1;
                  if (!started_q) begin
                     started_q <= 1'b1;
                     len_q     <= len_in;
                     rev_q     <= rev_order;
                     swap_q    <= swap_words;
                     if (num_data > 20'(DEPTH))
                        cfg_err_q <= 1'b1;
                  end
                  if (last_in)
                     state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_out) begin
                  state_q      <= RECV;
                  wr_cnt_q     <= '0;
                  rd_idx_q     <= '0;
                  out_idx_q    <= '0;
                  started_q    <= 1'b0;
                  busy_q       <= 1'b0;
                  frame_done_q <= 1'b1;
               end
            end
            default: state_q <= RECV;
         endcase
      end
   end

endmodule
